// File: rtl/fd_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// fd_pipe_reg_if
// Bundle of the F/D pipeline register's control and data signals.
//   Control (hazard unit / CP0 / decode -> register):
//     en         load enable, 0 = stall (hold)
//     req        exception/interrupt flush request from CP0
//     eret_d     instruction currently in D is eret
//     branch_d   instruction currently in D is a branch/jump
//   Fetch side (fetch -> register):
//     pc_f, instr_f, exccode_f
//   Decode side (register -> decode):
//     pc_d, instr_d, exccode_d, bd_d, valid_d
// master : the surrounding pipeline (drives fetch/control, observes D outputs)
// slave  : the pipeline register itself
// ---------------------------------------------------------------------------
interface fd_pipe_reg_if;
  logic        en;
  logic        req;
  logic        eret_d;
  logic        branch_d;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [4:0]  exccode_f;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic [4:0]  exccode_d;
  logic        bd_d;
  logic        valid_d;

  modport master (
    output en, req, eret_d, branch_d, pc_f, instr_f, exccode_f,
    input  pc_d, instr_d, exccode_d, bd_d, valid_d
  );

  modport slave (
    input  en, req, eret_d, branch_d, pc_f, instr_f, exccode_f,
    output pc_d, instr_d, exccode_d, bd_d, valid_d
  );
endinterface

// File: rtl/fd_pipe_reg.sv
// ---------------------------------------------------------------------------
// fd_pipe_reg
// F/D pipeline register of the five-stage MIPS core with precise exceptions.
// Captures the fetched instruction, its PC and fetch exception code, and
// presents them to decode with a branch-delay-slot flag and a valid bit.
// Handles stall hold, exception flush, eret flush and fetch-fault squashing.
// Ports:
//   clk    clock (all outputs update on posedge only)
//   reset  synchronous, active-high reset
//   bus    fd_pipe_reg_if.slave (control, fetch inputs, decode outputs)
// Per-edge priority: reset > req > stall (!en) > eret_d > normal load.
// Every output comes straight from a flop; there is no input-to-output
// combinational path.
// ---------------------------------------------------------------------------
module fd_pipe_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fd_pipe_reg_if.slave  bus
);

  localparam logic [4:0] EXC_NONE = 5'd0;

  logic [31:0] pc_reg_q,    pc_reg_d;
  logic [31:0] instr_reg_q, instr_reg_d;
  logic [4:0]  exc_reg_q,   exc_reg_d;
  logic        bd_reg_q,    bd_reg_d;
  logic        valid_reg_q, valid_reg_d;

  // Next-state selection by flush/stall/eret/load priority.
  always_comb begin
    pc_reg_d    = pc_reg_q;
    instr_reg_d = instr_reg_q;
    exc_reg_d   = exc_reg_q;
    bd_reg_d    = bd_reg_q;
    valid_reg_d = valid_reg_q;
    if (bus.req) begin
      // Flush wins over stall and eret; the bubble carries the handler PC.
      pc_reg_d    = HANDLER_PC;
      instr_reg_d = NOP_INSTR;
      exc_reg_d   = EXC_NONE;
      bd_reg_d    = 1'b0;
      valid_reg_d = 1'b0;
    end else if (!bus.en) begin
      // Stall: everything, including bd and valid, is held.
      pc_reg_d    = pc_reg_q;
      instr_reg_d = instr_reg_q;
      exc_reg_d   = exc_reg_q;
      bd_reg_d    = bd_reg_q;
      valid_reg_d = valid_reg_q;
    end else if (bus.eret_d) begin
      // eret has no delay slot: the word fetched behind it is dropped.
      pc_reg_d    = bus.pc_f;
      instr_reg_d = NOP_INSTR;
      exc_reg_d   = EXC_NONE;
      bd_reg_d    = 1'b0;
      valid_reg_d = 1'b0;
    end else begin
      pc_reg_d    = bus.pc_f;
      exc_reg_d   = bus.exccode_f;
      bd_reg_d    = bus.branch_d;
      valid_reg_d = 1'b1;
      // A faulting fetch keeps its PC/exccode for EPC but never decodes.
      if (bus.exccode_f != EXC_NONE) begin
        instr_reg_d = NOP_INSTR;
      end else begin
        instr_reg_d = bus.instr_f;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg_q    <= RESET_PC;
      instr_reg_q <= NOP_INSTR;
      exc_reg_q   <= EXC_NONE;
      bd_reg_q    <= 1'b0;
      valid_reg_q <= 1'b0;
    end else begin
      pc_reg_q    <= pc_reg_d;
      instr_reg_q <= instr_reg_d;
      exc_reg_q   <= exc_reg_d;
      bd_reg_q    <= bd_reg_d;
      valid_reg_q <= valid_reg_d;
    end
  end

  assign bus.pc_d      = pc_reg_q;
  assign bus.instr_d   = instr_reg_q;
  assign bus.exccode_d = exc_reg_q;
  assign bus.bd_d      = bd_reg_q;
  assign bus.valid_d   = valid_reg_q;

endmodule
